// File: rtl/angstrom_pkg.sv
// rtl/angstrom_pkg.sv - shared opcodes, state encoding and strobe bundle for the angstrom control unit
package angstrom_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_BRC = 4'h5;
    localparam logic [3:0] OP_BRZ = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ACC_SRC_ALU = 2'b00;
    localparam logic [1:0] ACC_SRC_MEM = 2'b01;
    localparam logic [1:0] ACC_SRC_IMM = 2'b10;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       pc_inc;
        logic       acc_we;
        logic [1:0] acc_src;
        logic       alu_sub;
        logic       out_we;
        logic       ctrl_jmp;
        logic       halted;
        logic       flag_we;
    } strobes_t;

    // Instructions that hold EXEC until memory signals ready.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_STA);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational strobe decode from state, IR opcode and memory ready
module ctrl_decode
    import angstrom_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output strobes_t   strobes
);

    // Output process of the sequencer FSM; only pc_inc and the LDA acc_we look at mem_ready.
    always_comb begin
        strobes = '0;
        case (state)
            ST_FETCH: begin
                strobes.mem_req = 1'b1;
                strobes.pc_inc  = mem_ready;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LDA: begin
                        strobes.mem_req  = 1'b1;
                        strobes.addr_sel = 1'b1;
                        strobes.acc_src  = ACC_SRC_MEM;
                        strobes.acc_we   = mem_ready;
                    end
                    OP_STA: begin
                        strobes.mem_req  = 1'b1;
                        strobes.mem_we   = 1'b1;
                        strobes.addr_sel = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        strobes.acc_we  = 1'b1;
                        strobes.acc_src = ACC_SRC_ALU;
                        strobes.alu_sub = (opcode == OP_SUB);
                        strobes.flag_we = 1'b1;
                    end
                    OP_LDI: begin
                        strobes.acc_we  = 1'b1;
                        strobes.acc_src = ACC_SRC_IMM;
                    end
                    OP_BRC, OP_BRZ, OP_JMP: strobes.ctrl_jmp = 1'b1;
                    OP_OUT:                 strobes.out_we   = 1'b1;
                    default:                ;
                endcase
            end
            ST_HALT: strobes.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle instruction sequencer owning state, IR and Z/C flags
module control_unit
    import angstrom_pkg::*;
#(
    parameter int INSTR_W = 8,
    parameter int OPR_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               mem_ready_i,
    input  logic               alu_z_i,
    input  logic               alu_c_i,
    output logic [3:0]         op_o,
    output logic [OPR_W-1:0]   operand_o,
    output logic               ctrl_jmp_o,
    output logic               flag_z_o,
    output logic               flag_c_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               addr_sel_o,
    output logic               pc_inc_o,
    output logic               acc_we_o,
    output logic [1:0]         acc_src_o,
    output logic               alu_sub_o,
    output logic               out_we_o,
    output logic               halted_o
);

    state_t             state;
    state_t             state_next;
    logic [INSTR_W-1:0] ir;
    logic               flag_z;
    logic               flag_c;
    strobes_t           dec;
    strobes_t           strb;

    assign op_o      = ir[INSTR_W-1 -: 4];
    assign operand_o = ir[OPR_W-1:0];

    // State register; reset abandons any outstanding memory wait.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state process; memory ops stall in EXEC, HLT parks until reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:  if (mem_ready_i) state_next = ST_DECODE;
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                if (op_o == OP_HLT) begin
                    state_next = ST_HALT;
                end else if (!is_mem_op(op_o) || mem_ready_i) begin
                    state_next = ST_FETCH;
                end
            end
            default:   state_next = ST_HALT;
        endcase
    end

    // IR captures the fetched word; flags update only from ADD/SUB in EXEC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir     <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            if (state == ST_FETCH && mem_ready_i) begin
                ir <= instr_i;
            end
            if (dec.flag_we) begin
                flag_z <= alu_z_i;
                flag_c <= alu_c_i;
            end
        end
    end

    ctrl_decode u_decode (
        .state     (state),
        .opcode    (op_o),
        .mem_ready (mem_ready_i),
        .strobes   (dec)
    );

    // Strobes are forced quiet while reset is held so the datapath sees no request mid-reset.
    always_comb begin
        strb = dec;
        if (rst_i) begin
            strb = '0;
        end
    end

    assign flag_z_o   = flag_z;
    assign flag_c_o   = flag_c;
    assign mem_req_o  = strb.mem_req;
    assign mem_we_o   = strb.mem_we;
    assign addr_sel_o = strb.addr_sel;
    assign pc_inc_o   = strb.pc_inc;
    assign acc_we_o   = strb.acc_we;
    assign acc_src_o  = strb.acc_src;
    assign alu_sub_o  = strb.alu_sub;
    assign out_we_o   = strb.out_we;
    assign ctrl_jmp_o = strb.ctrl_jmp;
    assign halted_o   = strb.halted;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit sequencing, strobes and flags
module tb_control_unit;

    // strobe vector bit order: mem_req mem_we addr_sel pc_inc acc_we acc_src[1:0] alu_sub out_we ctrl_jmp halted
    localparam logic [10:0] S_IDLE     = 11'h000;
    localparam logic [10:0] S_F_WAIT   = 11'h400;
    localparam logic [10:0] S_F_RDY    = 11'h480;
    localparam logic [10:0] S_LDA_WAIT = 11'h510;
    localparam logic [10:0] S_LDA_RDY  = 11'h550;
    localparam logic [10:0] S_STA      = 11'h700;
    localparam logic [10:0] S_ADD      = 11'h040;
    localparam logic [10:0] S_SUB      = 11'h048;
    localparam logic [10:0] S_LDI      = 11'h060;
    localparam logic [10:0] S_JMP      = 11'h002;
    localparam logic [10:0] S_OUT      = 11'h004;
    localparam logic [10:0] S_HALT     = 11'h001;

    typedef struct {
        logic        rst;
        logic [7:0]  instr;
        logic        rdy;
        logic        z;
        logic        c;
        logic [10:0] e_strb;
        logic        e_z;
        logic        e_c;
        logic [3:0]  e_op;
        logic [3:0]  e_opr;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       mem_ready = 1'b0;
    logic       alu_z = 1'b0;
    logic       alu_c = 1'b0;
    logic [3:0] op;
    logic [3:0] operand;
    logic       ctrl_jmp, flag_z, flag_c, mem_req, mem_we, addr_sel, pc_inc;
    logic       acc_we, alu_sub, out_we, halted;
    logic [1:0] acc_src;
    logic [10:0] strb;

    step_t       stim[$];
    logic [20:0] sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    control_unit #(.INSTR_W(8), .OPR_W(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .instr_i     (instr),
        .mem_ready_i (mem_ready),
        .alu_z_i     (alu_z),
        .alu_c_i     (alu_c),
        .op_o        (op),
        .operand_o   (operand),
        .ctrl_jmp_o  (ctrl_jmp),
        .flag_z_o    (flag_z),
        .flag_c_o    (flag_c),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .addr_sel_o  (addr_sel),
        .pc_inc_o    (pc_inc),
        .acc_we_o    (acc_we),
        .acc_src_o   (acc_src),
        .alu_sub_o   (alu_sub),
        .out_we_o    (out_we),
        .halted_o    (halted)
    );

    assign strb = {mem_req, mem_we, addr_sel, pc_inc, acc_we, acc_src, alu_sub, out_we, ctrl_jmp, halted};

    task automatic add_step(input logic r, input logic [7:0] i, input logic rd, input logic z, input logic c,
                            input logic [10:0] es, input logic ez, input logic ec,
                            input logic [3:0] eo, input logic [3:0] er);
        step_t s;
        s.rst = r; s.instr = i; s.rdy = rd; s.z = z; s.c = c;
        s.e_strb = es; s.e_z = ez; s.e_c = ec; s.e_op = eo; s.e_opr = er;
        stim.push_back(s);
    endtask

    task automatic drive(input step_t s);
        rst = s.rst; instr = s.instr; mem_ready = s.rdy; alu_z = s.z; alu_c = s.c;
        sb.push_back({s.e_strb, s.e_z, s.e_c, s.e_op, s.e_opr});
    endtask

    task automatic test_reset();
        step_t s; logic [20:0] e; int n = 0;
        add_step(1, 8'h00, 1, 0, 0, S_IDLE,   0, 0, 4'h0, 4'h0);
        add_step(0, 8'h00, 0, 0, 0, S_F_WAIT, 0, 0, 4'h0, 4'h0);
        while (stim.size() > 0) begin
            s = stim.pop_front(); drive(s); #1;
            e = sb.pop_front(); vectors++;
            if ({strb, flag_z, flag_c, op, operand} !== e) begin
                miscompares++;
                $display("FAIL reset cyc%0d: got %h want %h", n, {strb, flag_z, flag_c, op, operand}, e);
            end
            n++; @(negedge clk);
        end
    endtask

    task automatic test_add();
        step_t s; logic [20:0] e; int n = 0;
        add_step(0, 8'h25, 1, 0, 1, S_F_RDY, 0, 0, 4'h0, 4'h0);
        add_step(0, 8'h00, 1, 0, 1, S_IDLE,  0, 0, 4'h2, 4'h5);
        add_step(0, 8'h00, 1, 0, 1, S_ADD,   0, 0, 4'h2, 4'h5);
        while (stim.size() > 0) begin
            s = stim.pop_front(); drive(s); #1;
            e = sb.pop_front(); vectors++;
            if ({strb, flag_z, flag_c, op, operand} !== e) begin
                miscompares++;
                $display("FAIL add cyc%0d: got %h want %h", n, {strb, flag_z, flag_c, op, operand}, e);
            end
            n++; @(negedge clk);
        end
    endtask

    task automatic test_brz();
        step_t s; logic [20:0] e; int n = 0;
        add_step(0, 8'h21, 1, 1, 0, S_F_RDY,  0, 1, 4'h2, 4'h5);
        add_step(0, 8'h00, 1, 1, 0, S_IDLE,   0, 1, 4'h2, 4'h1);
        add_step(0, 8'h00, 1, 1, 0, S_ADD,    0, 1, 4'h2, 4'h1);
        add_step(0, 8'h63, 1, 0, 0, S_F_RDY,  1, 0, 4'h2, 4'h1);
        add_step(0, 8'h00, 1, 0, 0, S_IDLE,   1, 0, 4'h6, 4'h3);
        add_step(0, 8'h00, 1, 0, 0, S_JMP,    1, 0, 4'h6, 4'h3);
        add_step(0, 8'h00, 0, 0, 0, S_F_WAIT, 1, 0, 4'h6, 4'h3);
        while (stim.size() > 0) begin
            s = stim.pop_front(); drive(s); #1;
            e = sb.pop_front(); vectors++;
            if ({strb, flag_z, flag_c, op, operand} !== e) begin
                miscompares++;
                $display("FAIL brz cyc%0d: got %h want %h", n, {strb, flag_z, flag_c, op, operand}, e);
            end
            n++; @(negedge clk);
        end
    endtask

    task automatic test_lda_wait();
        step_t s; logic [20:0] e; int n = 0;
        add_step(0, 8'h0A, 1, 1, 1, S_F_RDY,    1, 0, 4'h6, 4'h3);
        add_step(0, 8'h00, 1, 1, 1, S_IDLE,     1, 0, 4'h0, 4'hA);
        for (int i = 0; i < 3; i++)
            add_step(0, 8'h00, 0, 1, 1, S_LDA_WAIT, 1, 0, 4'h0, 4'hA);
        add_step(0, 8'h00, 1, 1, 1, S_LDA_RDY,  1, 0, 4'h0, 4'hA);
        add_step(0, 8'h00, 0, 1, 1, S_F_WAIT,   1, 0, 4'h0, 4'hA);
        while (stim.size() > 0) begin
            s = stim.pop_front(); drive(s); #1;
            e = sb.pop_front(); vectors++;
            if ({strb, flag_z, flag_c, op, operand} !== e) begin
                miscompares++;
                $display("FAIL lda_wait cyc%0d: got %h want %h", n, {strb, flag_z, flag_c, op, operand}, e);
            end
            n++; @(negedge clk);
        end
    endtask

    task automatic test_undefined();
        step_t s; logic [20:0] e; int n = 0;
        add_step(0, 8'hA0, 1, 0, 1, S_F_RDY,  1, 0, 4'h0, 4'hA);
        add_step(0, 8'h00, 1, 0, 1, S_IDLE,   1, 0, 4'hA, 4'h0);
        add_step(0, 8'h00, 1, 0, 1, S_IDLE,   1, 0, 4'hA, 4'h0);
        add_step(0, 8'h00, 0, 0, 1, S_F_WAIT, 1, 0, 4'hA, 4'h0);
        while (stim.size() > 0) begin
            s = stim.pop_front(); drive(s); #1;
            e = sb.pop_front(); vectors++;
            if ({strb, flag_z, flag_c, op, operand} !== e) begin
                miscompares++;
                $display("FAIL undefined cyc%0d: got %h want %h", n, {strb, flag_z, flag_c, op, operand}, e);
            end
            n++; @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_lda();
        step_t s; logic [20:0] e; int n = 0;
        add_step(0, 8'h05, 1, 0, 0, S_F_RDY,    1, 0, 4'hA, 4'h0);
        add_step(0, 8'h00, 1, 0, 0, S_IDLE,     1, 0, 4'h0, 4'h5);
        add_step(0, 8'h00, 0, 0, 0, S_LDA_WAIT, 1, 0, 4'h0, 4'h5);
        add_step(1, 8'h00, 0, 0, 0, S_IDLE,     0, 0, 4'h0, 4'h0);
        add_step(0, 8'h00, 0, 0, 0, S_F_WAIT,   0, 0, 4'h0, 4'h0);
        while (stim.size() > 0) begin
            s = stim.pop_front(); drive(s); #1;
            e = sb.pop_front(); vectors++;
            if ({strb, flag_z, flag_c, op, operand} !== e) begin
                miscompares++;
                $display("FAIL reset_mid_lda cyc%0d: got %h want %h", n, {strb, flag_z, flag_c, op, operand}, e);
            end
            n++; @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        step_t s; logic [20:0] e; int n = 0;
        add_step(0, 8'h13, 1, 0, 0, S_F_RDY, 0, 0, 4'h0, 4'h0);
        add_step(0, 8'h00, 1, 0, 0, S_IDLE,  0, 0, 4'h1, 4'h3);
        add_step(0, 8'h00, 1, 0, 0, S_STA,   0, 0, 4'h1, 4'h3);
        add_step(0, 8'h32, 1, 1, 1, S_F_RDY, 0, 0, 4'h1, 4'h3);
        add_step(0, 8'h00, 1, 1, 1, S_IDLE,  0, 0, 4'h3, 4'h2);
        add_step(0, 8'h00, 1, 1, 1, S_SUB,   0, 0, 4'h3, 4'h2);
        add_step(0, 8'h47, 1, 0, 0, S_F_RDY, 1, 1, 4'h3, 4'h2);
        add_step(0, 8'h00, 1, 0, 0, S_IDLE,  1, 1, 4'h4, 4'h7);
        add_step(0, 8'h00, 1, 0, 0, S_LDI,   1, 1, 4'h4, 4'h7);
        add_step(0, 8'hE0, 1, 0, 0, S_F_RDY, 1, 1, 4'h4, 4'h7);
        add_step(0, 8'h00, 1, 0, 0, S_IDLE,  1, 1, 4'hE, 4'h0);
        add_step(0, 8'h00, 1, 0, 0, S_OUT,   1, 1, 4'hE, 4'h0);
        add_step(0, 8'h55, 1, 0, 0, S_F_RDY, 1, 1, 4'hE, 4'h0);
        add_step(0, 8'h00, 1, 0, 0, S_IDLE,  1, 1, 4'h5, 4'h5);
        add_step(0, 8'h00, 1, 0, 0, S_JMP,   1, 1, 4'h5, 4'h5);
        while (stim.size() > 0) begin
            s = stim.pop_front(); drive(s); #1;
            e = sb.pop_front(); vectors++;
            if ({strb, flag_z, flag_c, op, operand} !== e) begin
                miscompares++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", n, {strb, flag_z, flag_c, op, operand}, e);
            end
            n++; @(negedge clk);
        end
    endtask

    task automatic test_halt();
        step_t s; logic [20:0] e; int n = 0;
        add_step(0, 8'hF0, 1, 0, 0, S_F_RDY, 1, 1, 4'h5, 4'h5);
        add_step(0, 8'h00, 1, 0, 0, S_IDLE,  1, 1, 4'hF, 4'h0);
        add_step(0, 8'h00, 1, 0, 0, S_IDLE,  1, 1, 4'hF, 4'h0);
        for (int i = 0; i < 20; i++)
            add_step(0, 8'($urandom), 1'(i % 2), 1'($urandom), 1'($urandom), S_HALT, 1, 1, 4'hF, 4'h0);
        add_step(1, 8'h00, 1, 0, 0, S_IDLE,   0, 0, 4'h0, 4'h0);
        add_step(0, 8'h00, 0, 0, 0, S_F_WAIT, 0, 0, 4'h0, 4'h0);
        while (stim.size() > 0) begin
            s = stim.pop_front(); drive(s); #1;
            e = sb.pop_front(); vectors++;
            if ({strb, flag_z, flag_c, op, operand} !== e) begin
                miscompares++;
                $display("FAIL halt cyc%0d: got %h want %h", n, {strb, flag_z, flag_c, op, operand}, e);
            end
            n++; @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_brz();
        test_lda_wait();
        test_undefined();
        test_reset_mid_lda();
        test_back_to_back();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle instruction sequencer for the angstrom CPU.
- Fetches an 8-bit instruction (opcode[7:4], operand[3:0]) and holds it in an internal IR.
- Drives the datapath and memory strobes, owns the Z/C flag register, and produces op_o, flag_z_o, flag_c_o and ctrl_jmp_o for the branch unit.
- The branch unit's branch_o loads the PC directly; this block does not consume it.

Parameters:
- INSTR_W, 8, instruction width; upper 4 bits are the opcode.
- OPR_W, 4, operand/immediate width.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- instr_i  in  INSTR_W  memory read data, sampled as an instruction in FETCH
- mem_ready_i  in  1  memory completes the current request this cycle
- alu_z_i  in  1  ALU zero result
- alu_c_i  in  1  ALU carry/borrow result
- op_o  out  4  IR opcode, to the branch unit
- operand_o  out  OPR_W  IR operand: address or immediate
- ctrl_jmp_o  out  1  branch-evaluate strobe, to the branch unit
- flag_z_o  out  1  registered Z flag
- flag_c_o  out  1  registered C flag
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write (STA only)
- addr_sel_o  out  1  address source: 0 = PC, 1 = operand
- pc_inc_o  out  1  PC increment strobe
- acc_we_o  out  1  accumulator write
- acc_src_o  out  2  accumulator source: 00 ALU, 01 MEM, 10 IMM
- alu_sub_o  out  1  ALU subtract select
- out_we_o  out  1  output port write
- halted_o  out  1  core halted

Behaviour:
- Reset (async, any state, including a pending memory wait):
  - state = FETCH; IR = 0x00; flags = 0.
  - All strobes 0, acc_src_o = 00, halted_o = 0.
  - Any outstanding memory request is abandoned.
- Opcodes:
  - 0000 LDA, 0001 STA, 0010 ADD, 0011 SUB, 0100 LDI, 0101 BRC, 0110 BRZ, 0111 JMP, 1110 OUT, 1111 HLT.
  - All other opcodes are NOPs.
- States: FETCH, DECODE, EXEC, HALT.
- FETCH:
  - mem_req_o = 1, addr_sel_o = 0.
  - On a cycle with mem_ready_i = 1: pc_inc_o = 1 (Mealy); IR <= instr_i at the edge; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle; all strobes 0; next state EXEC.
- EXEC, by opcode:
  - LDA: mem_req_o = 1, addr_sel_o = 1, acc_src_o = 01. Wait for mem_ready_i. acc_we_o = mem_ready_i (Mealy). On ready, go to FETCH.
  - STA: mem_req_o = 1, mem_we_o = 1, addr_sel_o = 1. Wait for mem_ready_i. On ready, go to FETCH.
  - ADD/SUB: one cycle. acc_we_o = 1, acc_src_o = 00, alu_sub_o = (op == SUB). Flags <= {alu_z_i, alu_c_i} at the edge. Go to FETCH.
  - LDI: one cycle. acc_we_o = 1, acc_src_o = 10. Go to FETCH.
  - BRC/BRZ/JMP: one cycle. ctrl_jmp_o = 1, PC load occurs at the same edge. Go to FETCH.
  - OUT: one cycle. out_we_o = 1. Go to FETCH.
  - HLT: go to HALT.
  - NOP: no strobes. Go to FETCH.
- HALT: halted_o = 1; all strobes 0; instr_i and mem_ready_i ignored; leave only via rst_i.
- Flags:
  - Written only by ADD/SUB in EXEC. LDA, LDI and branches leave them unchanged.
  - A branch therefore evaluates the flags produced by the most recent ADD/SUB.
- Handshake:
  - mem_ready_i is ignored whenever mem_req_o = 0.
  - mem_req_o stays asserted and stable until the ready cycle.
  - No back-to-back requests without an intervening DECODE or FETCH transition.
- Latency with zero-wait memory:
  - ALU, branch, OUT and NOP instructions take 3 cycles.
  - LDA/STA take 3 cycles plus memory waits.
  - Each memory wait cycle adds exactly 1 cycle.
- Outputs:
  - op_o and operand_o are taken directly from IR; they are stable from DECODE through EXEC.
  - All strobes other than the Mealy pc_inc_o and LDA acc_we_o decode from the registered state and IR only.

Decomposition:
- angstrom_pkg holds:
  - opcode constants;
  - state encoding (2 bits);
  - ACC_SRC_ALU/MEM/IMM constants.
- One natural combinational sub-module, ctrl_decode:
  - inputs: state, IR opcode, mem_ready_i;
  - outputs: the strobe vector.
- control_unit keeps the state register, IR and flag register.

Test Plan:
- Reset mid-LDA: assert rst_i while in EXEC waiting for mem_ready_i -> same cycle: all strobes 0, op_o = 0000, flags 0; the next instruction is fetched with addr_sel_o = 0.
- ADD with mem_ready_i tied 1, alu_z_i = 0, alu_c_i = 1, instr 0x25 -> cycle 0 mem_req_o = 1 and pc_inc_o = 1; cycle 2 acc_we_o = 1 and acc_src_o = 00; afterwards flag_c_o = 1 and flag_z_o = 0.
- BRZ 0x63 after an ADD that set Z -> EXEC: ctrl_jmp_o = 1 for exactly one cycle, op_o = 0110, operand_o = 3, flag_z_o = 1.
- LDA 0x0A with mem_ready_i low for 3 EXEC cycles -> mem_req_o = 1 and addr_sel_o = 1 held 4 cycles; acc_we_o = 1 only in the ready cycle; flags unchanged.
- HLT 0xF0 -> halted_o = 1 from the EXEC+1 cycle; mem_req_o stays 0 for 20 cycles despite mem_ready_i toggling; rst_i clears halted_o.
- Undefined 0xA0 -> no strobes in DECODE or EXEC; FETCH resumes on cycle 3; flags unchanged.
